// File: rtl/wb_config_shifter.sv
// wb_config_shifter: Wishbone slave that loads per-column 32-bit config words
// and streams them LSB first into one fabric region's config chains, with an
// optional one-cycle set (latch) pulse afterwards.
// Optional feature: define WB_CFG_READBACK_EN to add the cfg_return port.
// This captures the chain tail bits into the buffers during a shift and makes
// DATA registers readable.
`timescale 1ns/1ps
module wb_config_shifter #(
  parameter int          CONFIG_COL_WIDTH = 4,
  parameter int          WORD_BITS        = 32,
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_data_i,
  input  logic [31:0]                 wbs_addr_i,
`ifdef WB_CFG_READBACK_EN
  input  logic [CONFIG_COL_WIDTH-1:0] cfg_return,
`endif
  output logic                        wbs_ack_o,
  output logic [31:0]                 wbs_data_o,
  output logic                        cen,
  output logic [CONFIG_COL_WIDTH-1:0] set_out,
  output logic [CONFIG_COL_WIDTH-1:0] shift_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, SETP} state_t;

  state_t                      state, state_nx;
  logic [31:0]                 data_buf   [CONFIG_COL_WIDTH];
  logic [31:0]                 data_shift [CONFIG_COL_WIDTH];
  logic                        auto_set;
  logic [15:0]                 word_count;
  logic [5:0]                  bit_cnt;
  logic                        last_bit;
  logic                        hit, busy, stall, accept;
  logic                        is_ctrl, is_status, ctrl_wr, go_cmd, set_cmd;
  logic [CONFIG_COL_WIDTH-1:0] col_sel, fill;
  logic [31:0]                 rd_data, wr_mask;
  logic                        cen_d;
  logic [CONFIG_COL_WIDTH-1:0] set_d, shift_d;

`ifdef WB_CFG_READBACK_EN
  assign fill = cfg_return;
`else
  assign fill = '0;
`endif

  assign last_bit = (bit_cnt == 6'(WORD_BITS - 1));

  // Address decode, stall qualification and read-data selection.
  always_comb begin
    hit       = wbs_cyc_i & wbs_stb_i & (wbs_addr_i[31:8] == BASE_ADDR[31:8]);
    is_ctrl   = (wbs_addr_i[7:0] == 8'h00);
    is_status = (wbs_addr_i[7:0] == 8'h04);
    col_sel   = '0;
    for (int unsigned c = 0; c < CONFIG_COL_WIDTH; c++) begin
      if ((32'h10 + 4 * c) < 32'h100 && wbs_addr_i[7:0] == 8'(32'h10 + 4 * c))
        col_sel[c] = 1'b1;
    end
    busy    = (state != IDLE);
    // Only writes that would disturb an active shift wait; reads never stall.
    stall   = busy & wbs_we_i &
              ((|col_sel) | (is_ctrl & wbs_sel_i[0] & (wbs_data_i[1] | wbs_data_i[2])));
    accept  = hit & ~wbs_ack_o & ~stall;
    ctrl_wr = accept & wbs_we_i & is_ctrl & wbs_sel_i[0];
    go_cmd  = ctrl_wr & wbs_data_i[1];
    set_cmd = ctrl_wr & wbs_data_i[2];
    wr_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    rd_data = '0;
    if (is_ctrl)
      rd_data = {31'b0, auto_set};
    else if (is_status)
      rd_data = {word_count, 15'b0, busy};
`ifdef WB_CFG_READBACK_EN
    for (int unsigned c = 0; c < CONFIG_COL_WIDTH; c++) begin
      if (col_sel[c])
        rd_data = data_buf[c];
    end
`endif
  end

  // Next buffer contents for one shift step: right shift, fill at the word's top bit.
  always_comb begin
    for (int unsigned c = 0; c < CONFIG_COL_WIDTH; c++) begin
      data_shift[c]              = {1'b0, data_buf[c][31:1]};
      data_shift[c][WORD_BITS-1] = fill[c];
    end
  end

  // FSM next state and the next values of the registered fabric outputs.
  always_comb begin
    state_nx = state;
    cen_d    = 1'b0;
    set_d    = '0;
    shift_d  = '0;
    case (state)
      IDLE: begin
        if (go_cmd)
          state_nx = SHIFT;
        else if (set_cmd)
          state_nx = SETP;
      end
      SHIFT: begin
        cen_d = 1'b1;
        for (int unsigned c = 0; c < CONFIG_COL_WIDTH; c++)
          shift_d[c] = data_buf[c][0];
        if (last_bit)
          state_nx = auto_set ? SETP : IDLE;
      end
      SETP: begin
        set_d    = '1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Bus response, output registers, buffers and counters.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_data_o <= '0;
      cen        <= 1'b0;
      set_out    <= '0;
      shift_out  <= '0;
      auto_set   <= 1'b0;
      word_count <= '0;
      bit_cnt    <= '0;
      for (int unsigned c = 0; c < CONFIG_COL_WIDTH; c++)
        data_buf[c] <= '0;
    end else begin
      wbs_ack_o  <= accept;
      wbs_data_o <= (accept && !wbs_we_i) ? rd_data : '0;
      cen        <= cen_d;
      set_out    <= set_d;
      shift_out  <= shift_d;
      if (ctrl_wr)
        auto_set <= wbs_data_i[0];
      if (go_cmd)
        bit_cnt <= '0;
      else if (state == SHIFT)
        bit_cnt <= last_bit ? '0 : bit_cnt + 6'd1;
      if (state == SHIFT && last_bit)
        word_count <= word_count + 16'd1;
      for (int unsigned c = 0; c < CONFIG_COL_WIDTH; c++) begin
        if (accept && wbs_we_i && col_sel[c])
          data_buf[c] <= (data_buf[c] & ~wr_mask) | (wbs_data_i & wr_mask);
        else if (state == SHIFT)
          data_buf[c] <= data_shift[c];
      end
    end
  end

endmodule

// File: tb/tb_wb_config_shifter.sv
// Testbench for wb_config_shifter: directed bus transactions against a
// cycle-indexed expectation model of the fabric-side outputs.
`timescale 1ns/1ps
module tb_wb_config_shifter;
  localparam int COLS = 4;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
  logic [3:0]      sel = '0;
  logic [31:0]     wdat = '0, addr = '0;
  logic            ack, cen;
  logic [31:0]     rdat;
  logic [COLS-1:0] set_out, shift_out;
  logic [COLS-1:0] cfg_ret = '0;

  int n_checks = 0, n_fail = 0;
  int edge_cnt = 0;

  typedef struct packed {
    logic            cen;
    logic [COLS-1:0] set;
    logic [COLS-1:0] shift;
  } outs_t;

  outs_t       exp_q[$];
  outs_t       cmp_e;
  bit          chk_en = 1'b0;
  logic        cap0[$];
  int          ones3 = 0, set_cnt = 0;

  // Model state
  logic [31:0] m_buf[COLS];
  bit          m_auto;
  int          m_wc, m_idle_edge, m_wc_edge;

  wb_config_shifter #(
    .CONFIG_COL_WIDTH(COLS),
    .WORD_BITS(32),
    .BASE_ADDR(32'h3000_0000)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc_i),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_data_i(wdat),
    .wbs_addr_i(addr),
`ifdef WB_CFG_READBACK_EN
    .cfg_return(cfg_ret),
`endif
    .wbs_ack_o(ack),
    .wbs_data_o(rdat),
    .cen(cen),
    .set_out(set_out),
    .shift_out(shift_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison of fabric outputs against the expectation queue.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check("cen", 32'(cen), 32'(cmp_e.cen));
      check("set_out", 32'(set_out), 32'(cmp_e.set));
      check("shift_out", 32'(shift_out), 32'(cmp_e.shift));
      if (!ack) check("data_o idle", rdat, 32'h0);
      if (cen) begin
        cap0.push_back(shift_out[0]);
        ones3 += int'(shift_out[3]);
      end
      if (|set_out) set_cnt++;
    end
  end

  task automatic m_init();
    for (int c = 0; c < COLS; c++) m_buf[c] = '0;
    m_auto = 1'b0; m_wc = 0; m_idle_edge = 0; m_wc_edge = -1;
  endtask

  // GO accepted at edge a: idle for the ack cycle, then 32 bits LSB first, optional set.
  task automatic m_go(input int a);
    outs_t e;
    exp_q.push_back('0);
    for (int k = 0; k < 32; k++) begin
      e = '0;
      e.cen = 1'b1;
      for (int c = 0; c < COLS; c++) e.shift[c] = m_buf[c][k];
      exp_q.push_back(e);
    end
    if (m_auto) begin
      e = '0; e.set = '1;
      exp_q.push_back(e);
    end
    for (int c = 0; c < COLS; c++) m_buf[c] = '0;
    m_wc_edge   = a + 32;
    m_wc        = (m_wc + 1) & 16'hFFFF;
    m_idle_edge = a + 33 + (m_auto ? 1 : 0);
  endtask

  task automatic m_setp(input int a);
    outs_t e;
    exp_q.push_back('0);
    e = '0; e.set = '1;
    exp_q.push_back(e);
    m_idle_edge = a + 2;
  endtask

  function automatic logic [31:0] m_read(input int off, input int a);
    int wc;
    if (off == 0) return {31'b0, m_auto};
    if (off == 4) begin
      wc = (a > m_wc_edge) ? m_wc : ((m_wc - 1) & 16'hFFFF);
      return {wc[15:0], 15'b0, (a < m_idle_edge) ? 1'b1 : 1'b0};
    end
`ifdef WB_CFG_READBACK_EN
    if (off >= 16 && off < 16 + 4 * COLS && off % 4 == 0) return m_buf[(off - 16) / 4];
`endif
    return 32'h0;
  endfunction

  // One bus access, presented at posedge+2; expected ack edge comes from the model.
  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string name, output logic [31:0] rd);
    int  c0, exp_edge, off, col, waited, acc;
    bit  hit_m, is_col, stalls;
    hit_m  = (a[31:8] == 24'h300000);
    off    = int'(a[7:0]);
    is_col = (off >= 16 && off < 16 + 4 * COLS && off % 4 == 0);
    col    = (off - 16) / 4;
    stalls = w && (is_col || (off == 0 && s[0] && (d[1] || d[2])));
    stb = 1'b1; cyc_i = 1'b1; we = w; addr = a; wdat = d; sel = s;
    c0 = edge_cnt;
    exp_edge = c0 + 1;
    if (stalls && m_idle_edge > exp_edge) exp_edge = m_idle_edge;
    rd = '0;
    if (!hit_m) begin
      repeat (3) begin
        @(posedge clk); #2;
        check({name, " no-ack"}, 32'(ack), 32'h0);
        check({name, " no-data"}, rdat, 32'h0);
      end
    end else begin
      waited = 0;
      do begin
        @(posedge clk); #2;
        waited++;
      end while (!ack && waited < 200);
      if (!ack) begin
        n_checks++; n_fail++;
        $display("FAIL %s ack timeout: got no ack within %0d cycles", name, waited);
      end else begin
        acc = edge_cnt;
        check({name, " ack edge"}, acc, exp_edge);
        rd = rdat;
        if (w) begin
          if (off == 0 && s[0]) begin
            m_auto = d[0];
            if (d[1]) m_go(acc);
            else if (d[2]) m_setp(acc);
          end else if (is_col) begin
            for (int b = 0; b < 4; b++)
              if (s[b]) m_buf[col][8*b +: 8] = d[8*b +: 8];
          end
        end else begin
          check({name, " rdata"}, rdat, m_read(off, acc));
        end
      end
    end
    stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
    @(posedge clk); #2;
    check({name, " ack one-shot"}, 32'(ack), 32'h0);
  endtask

  logic [31:0] rd;
  logic [7:0]  first8;
  int          tail;

  initial begin
    m_init();
    // 1: reset and first STATUS read
    repeat (2) @(posedge clk);
    #2;
    check("reset ack", 32'(ack), 32'h0);
    check("reset data_o", rdat, 32'h0);
    check("reset cen", 32'(cen), 32'h0);
    check("reset set_out", 32'(set_out), 32'h0);
    check("reset shift_out", 32'(shift_out), 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    bus(1'b0, 32'h3000_0004, '0, 4'hF, "t1 status", rd);
    check("t1 status literal", rd, 32'h0000_0000);

    // 2: shift 0xA5 out of column 0, no set pulse
    cap0.delete(); set_cnt = 0;
    bus(1'b1, 32'h3000_0010, 32'h0000_00A5, 4'hF, "t2 data0", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0002, 4'hF, "t2 go", rd);
    repeat (33) @(posedge clk);
    #2;
    check("t2 bit count", cap0.size(), 32);
    first8 = '0; tail = 0;
    for (int i = 0; i < cap0.size(); i++) begin
      if (i < 8) first8[i] = cap0[i];
      else tail += int'(cap0[i]);
    end
    check("t2 first bits", 32'(first8), 32'h0000_00A5);
    check("t2 tail ones", tail, 0);
    check("t2 set pulses", set_cnt, 0);
    bus(1'b0, 32'h3000_0004, '0, 4'hF, "t2 status", rd);
    check("t2 status literal", rd, 32'h0001_0000);

    // 3: all ones on column 3 with AUTO_SET
    ones3 = 0; set_cnt = 0;
    bus(1'b1, 32'h3000_001C, 32'hFFFF_FFFF, 4'hF, "t3 data3", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, "t3 go", rd);
    repeat (35) @(posedge clk);
    #2;
    check("t3 ones", ones3, 32);
    check("t3 set pulses", set_cnt, 1);

    // 4: stalls during busy, STATUS during shift, byte lanes, GO+SET, SET alone
    bus(1'b1, 32'h3000_0010, 32'h8000_0001, 4'hF, "t4 data0", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, "t4 go auto", rd);
    bus(1'b0, 32'h3000_0004, '0, 4'hF, "t4 status busy", rd);
    check("t4 busy bit", 32'(rd[0]), 32'h1);
    bus(1'b1, 32'h3000_0014, 32'h0000_0003, 4'hF, "t4 data1 stalled", rd);
    bus(1'b0, 32'h3000_0000, '0, 4'hF, "t4 ctrl read", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0002, 4'hF, "t4 go", rd);
    bus(1'b1, 32'h3000_0018, 32'hFFFF_FF5A, 4'h1, "t4 data2 lane0", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0006, 4'hF, "t4 go+set", rd);
    repeat (34) @(posedge clk);
    #2;
    bus(1'b1, 32'h3000_0000, 32'h0000_0004, 4'hF, "t4 set", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0002, 4'hE, "t4 ctrl no lane0", rd);
    bus(1'b0, 32'h3000_0010, '0, 4'hF, "t4 data0 read", rd);
    bus(1'b0, 32'h3000_0004, '0, 4'hF, "t4 status", rd);
    check("t4 status literal", rd, 32'h0005_0000);

    // 5: miss and unmapped offset
    bus(1'b0, 32'h3000_0100, '0, 4'hF, "t5 miss", rd);
    bus(1'b0, 32'h3000_0040, '0, 4'hF, "t5 unmapped read", rd);
    check("t5 unmapped literal", rd, 32'h0);
    bus(1'b1, 32'h3000_0040, 32'hDEAD_BEEF, 4'hF, "t5 unmapped write", rd);

    // 6: reset at bit 10 of a shift
    bus(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'hF, "t6 data0", rd);
    bus(1'b1, 32'h3000_0000, 32'h0000_0003, 4'hF, "t6 go", rd);
    repeat (9) @(posedge clk);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk); #2;
    check("t6 cen", 32'(cen), 32'h0);
    check("t6 shift_out", 32'(shift_out), 32'h0);
    check("t6 set_out", 32'(set_out), 32'h0);
    rst_n = 1'b1;
    exp_q.delete();
    m_init();
    set_cnt = 0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("t6 no set pulse", set_cnt, 0);
    bus(1'b0, 32'h3000_0004, '0, 4'hF, "t6 status", rd);
    check("t6 status literal", rd, 32'h0000_0000);

    repeat (2) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_config_shifter.md
Name: wb_config_shifter

Overview:
Wishbone slave that turns 32-bit bus writes into serial configuration bitstreams for one fabric configuration region of CONFIG_COL_WIDTH columns. It sits directly upstream of the fabric top level. It drives that region's cen and the per-column shift and set inputs at the bottom (row 0) of each column's config chain. One instance exists per region. Its wbs_ack_o and wbs_data_o are ORed with the other instances' outputs, so both must be 0 whenever the bus access is not addressed to this instance.

Parameters:
CONFIG_COL_WIDTH, 4, number of columns driven; one shift bit and one set bit per column.
WORD_BITS, 32, bits shifted per GO command (1..32); LSB first.
BASE_ADDR, 32'h3000_0000, region base; decoded on wbs_addr_i[31:8].

Ports:
wb_clk_i  in  1  single clock (bus and fabric config).
wb_rst_i  in  1  reset, synchronous, active-low.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte write mask.
wbs_data_i  in  32  write data.
wbs_addr_i  in  32  byte address.
wbs_ack_o  out  1  single-cycle acknowledge.
wbs_data_o  out  32  read data; 0 when not acking.
cen  out  1  config clock-enable to every column of the region.
set_out  out  CONFIG_COL_WIDTH  per-column set (latch) pulse.
shift_out  out  CONFIG_COL_WIDTH  per-column serial config data.

Behaviour:
- Hit: cyc & stb & (wbs_addr_i[31:8] == BASE_ADDR[31:8]). A miss produces no ack; wbs_data_o stays 0.
- Register map (offset = addr[7:0]):
  - 0x00 CTRL: bit0 AUTO_SET (R/W); bit1 GO (write-1, self-clearing, reads 0); bit2 SET (write-1 pulse, reads 0). Written only when sel[0]=1.
  - 0x04 STATUS (RO): bit0 busy; [31:16] word_count.
  - 0x10+4*c DATA[c], for c < CONFIG_COL_WIDTH: 32-bit column buffer; byte lanes are written per wbs_sel_i.
  - Any other offset: write ignored, read 0, still acked.
- Ack:
  - Registered; asserted the cycle after the hit is seen, for exactly one cycle.
  - No re-ack while stb is held in the ack cycle; a new ack needs a new hit evaluated after the ack cycle.
  - Reads never stall.
  - A write to DATA, or a CTRL write with GO=1 or SET=1, that arrives while busy=1 stalls (no ack, no effect) until the FSM is IDLE. It is then performed and acked the next cycle.
- FSM states and transitions:
  - IDLE: cen=0, set_out=0, shift_out=0. GO → SHIFT with bit counter=0. SET (with GO=0) → SETP. GO and SET in the same write: GO wins, SET is ignored.
  - SHIFT: cen=1. shift_out[c]=DATA[c][0]. Each cycle every DATA[c] shifts right one bit with 0 into bit 31. After WORD_BITS cycles: word_count+=1 (wraps 0xFFFF→0), then → SETP if AUTO_SET else → IDLE. busy=1.
  - SETP: exactly one cycle; set_out = all ones, cen=0, shift_out=0 → IDLE. busy=1.
- Latency: first data bit appears on shift_out on the cycle after the GO ack cycle.
- All outputs are registered.
- Reset values: wbs_ack_o=0, wbs_data_o=0, cen=0, set_out=0, shift_out=0, DATA=0, AUTO_SET=0, word_count=0, state IDLE.
- A reset asserted mid-SHIFT or mid-SETP forces the reset values on the next edge. No partial set pulse is emitted.

Optional Feature:
Macro WB_CFG_READBACK_EN.
- Defined:
  - Adds input cfg_return [CONFIG_COL_WIDTH-1:0], the tail bit of each column chain.
  - During SHIFT, DATA[c] shifts in cfg_return[c] at bit WORD_BITS-1 instead of 0.
  - DATA reads return the buffer, so after a full pass it holds the bits shifted out of the chain.
- Undefined: the port is absent, zero fill applies, and DATA reads return 0.

Test Plan:
1. Reset low for 2 cycles, then high → all outputs 0; STATUS read returns 0x0000_0000 and is acked after 1 cycle.
2. Write DATA[0]=0x0000_00A5, then CTRL=0x2 (GO) → cen=1 for 32 cycles; shift_out[0] sequence starts 1,0,1,0,0,1,0,1 followed by 24 zeros; no set pulse; STATUS then reads 0x0001_0000.
3. CTRL=0x3 (AUTO_SET+GO) with DATA[3]=0xFFFF_FFFF → 32 ones on shift_out[3], then set_out=4'b1111 for exactly one cycle with cen=0, then IDLE.
4. Write DATA[1] on the cycle after GO is acked → ack is withheld for 32 cycles (33 with AUTO_SET) and the buffer is updated only after IDLE; a STATUS read during the shift acks in 1 cycle with busy=1.
5. Access at 0x3000_0100 and at 0x3000_0040 → the first gets no ack and data_o=0; the second is acked with read data 0.
6. Reset asserted at bit 10 of a shift → cen=0 and shift_out=0 on the next edge; word_count stays 0.
